// File: rtl/axi_rd_arbiter_rr.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter_rr
//
// Shares one AXI read port among NUM_REQ cache-side requesters (0 = dcache,
// 1 = icache, higher slots for prefetch / page-table walker). A grant covers a
// whole burst: it is taken when the AR is registered and released when the R
// beat carrying rlast is accepted. The AR path is registered; the R path is
// purely combinational and steered only to the granted requester.
//
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   req_araddr / req_arvalid    per-requester AR (slice i = [i*ADDR_WIDTH +: ADDR_WIDTH])
//   req_arready                 one-cycle pulse to the granted requester on AR handshake
//   req_rdata/rresp/rlast       R payload, broadcast to every requester
//   req_rvalid / req_rready     per-requester R handshake, only bit [grant_idx] live
//   m_ar* / m_r*                shared master-side AR and R channels
//   grant_idx                   current (or last) granted requester
//   busy                        high while a burst is in flight (S_AR or S_R)
// -----------------------------------------------------------------------------
module axi_rd_arbiter_rr #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int RR_MODE    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_REQ-1:0]            req_arvalid,
    output logic [NUM_REQ-1:0]            req_arready,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic [1:0]                    req_rresp,
    output logic                          req_rlast,
    output logic [NUM_REQ-1:0]            req_rvalid,
    input  logic [NUM_REQ-1:0]            req_rready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_e;

    state_e                state_q,   state_d;
    logic [IDX_W-1:0]      grant_q,   grant_d;
    logic [IDX_W-1:0]      rr_ptr_q,  rr_ptr_d;
    logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
    logic                  arvalid_q, arvalid_d;

    logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
    logic [IDX_W-1:0]      win_idx;
    logic                  win_found;
    int                    cand;
    logic                  r_done;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign req_addr[i] = req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Winner search. In round-robin mode the scan starts at rr_ptr and wraps;
    // in fixed-priority mode it always starts at index 0.
    // NOTE: every signal driven from always_comb gets a default on entry, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (RR_MODE != 0) ? int'(rr_ptr_q) + k : k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req_arvalid[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // values from before the edge, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        r_done    = m_rvalid && m_rready && m_rlast;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d   = win_idx;
                    araddr_d  = req_addr[win_idx];
                    arvalid_d = 1'b1;
                    state_d   = S_AR;
                end
            end
            S_AR: begin
                if (arvalid_q && m_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (r_done) begin
                    state_d  = S_IDLE;
                    // Next search starts just past the requester that finished.
                    rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: AR acknowledge and R steering, both decoded from the grant.
    always_comb begin
        req_arready = '0;
        req_rvalid  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                req_arready[i] = (state_q == S_AR) && arvalid_q && m_arready;
                req_rvalid[i]  = (state_q == S_R) && m_rvalid;
            end
        end
        m_rready = (state_q == S_R) && req_rready[grant_q];
        busy     = (state_q != S_IDLE);
    end

    assign m_araddr  = araddr_q;
    assign m_arvalid = arvalid_q;
    assign grant_idx = grant_q;
    assign req_rdata = m_rdata;
    assign req_rresp = m_rresp;
    assign req_rlast = m_rlast;

endmodule

// File: tb/tb_axi_rd_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter_rr
//
// Directed bench for axi_rd_arbiter_rr. Three instances:
//   dut_rr : NUM_REQ=2, round-robin
//   dut_fp : NUM_REQ=2, fixed priority (same stimulus as dut_rr)
//   dut3   : NUM_REQ=3, round-robin, 16-bit address/data
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter_rr;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Shared stimulus for the two 2-way instances.
    logic [127:0] req_araddr;
    logic [1:0]   req_arvalid;
    logic [1:0]   req_rready;
    logic         m_arready;
    logic [63:0]  m_rdata;
    logic [1:0]   m_rresp;
    logic         m_rlast;
    logic         m_rvalid;

    logic [1:0]  arready_rr, rvalid_rr, arready_fp, rvalid_fp;
    logic [63:0] rdata_rr, rdata_fp, m_araddr_rr, m_araddr_fp;
    logic [1:0]  rresp_rr, rresp_fp;
    logic        rlast_rr, rlast_fp, m_arvalid_rr, m_arvalid_fp;
    logic        m_rready_rr, m_rready_fp, busy_rr, busy_fp;
    logic        grant_rr, grant_fp;

    // Stimulus and outputs for the 3-way instance.
    logic [47:0] req_araddr3;
    logic [2:0]  req_arvalid3, req_rready3;
    logic        m_arready3, m_rlast3, m_rvalid3;
    logic [15:0] m_rdata3;
    logic [1:0]  m_rresp3;
    logic [2:0]  arready3, rvalid3;
    logic [15:0] rdata3, m_araddr3;
    logic [1:0]  rresp3, grant3;
    logic        rlast3, m_arvalid3, m_rready3, busy3;

    axi_rd_arbiter_rr #(.NUM_REQ(2), .ADDR_WIDTH(64), .DATA_WIDTH(64), .RR_MODE(1)) dut_rr (
        .clk(clk), .reset(reset),
        .req_araddr(req_araddr), .req_arvalid(req_arvalid), .req_arready(arready_rr),
        .req_rdata(rdata_rr), .req_rresp(rresp_rr), .req_rlast(rlast_rr),
        .req_rvalid(rvalid_rr), .req_rready(req_rready),
        .m_araddr(m_araddr_rr), .m_arvalid(m_arvalid_rr), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready_rr), .grant_idx(grant_rr), .busy(busy_rr)
    );

    axi_rd_arbiter_rr #(.NUM_REQ(2), .ADDR_WIDTH(64), .DATA_WIDTH(64), .RR_MODE(0)) dut_fp (
        .clk(clk), .reset(reset),
        .req_araddr(req_araddr), .req_arvalid(req_arvalid), .req_arready(arready_fp),
        .req_rdata(rdata_fp), .req_rresp(rresp_fp), .req_rlast(rlast_fp),
        .req_rvalid(rvalid_fp), .req_rready(req_rready),
        .m_araddr(m_araddr_fp), .m_arvalid(m_arvalid_fp), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready_fp), .grant_idx(grant_fp), .busy(busy_fp)
    );

    axi_rd_arbiter_rr #(.NUM_REQ(3), .ADDR_WIDTH(16), .DATA_WIDTH(16), .RR_MODE(1)) dut3 (
        .clk(clk), .reset(reset),
        .req_araddr(req_araddr3), .req_arvalid(req_arvalid3), .req_arready(arready3),
        .req_rdata(rdata3), .req_rresp(rresp3), .req_rlast(rlast3),
        .req_rvalid(rvalid3), .req_rready(req_rready3),
        .m_araddr(m_araddr3), .m_arvalid(m_arvalid3), .m_arready(m_arready3),
        .m_rdata(m_rdata3), .m_rresp(m_rresp3), .m_rlast(m_rlast3), .m_rvalid(m_rvalid3),
        .m_rready(m_rready3), .grant_idx(grant3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One single-beat burst on the 3-way instance, starting from S_IDLE.
    task automatic burst3(input int g, input logic [15:0] addr);
        tick();
        check("rr3_grant", 64'(grant3), 64'(g));
        check("rr3_araddr", 64'(m_araddr3), 64'(addr));
        check("rr3_arvalid", 64'(m_arvalid3), 64'd1);
        m_arready3 = 1'b1;
        #1;
        check("rr3_arready", 64'(arready3), 64'd1 << g);
        tick();
        m_arready3 = 1'b0;
        m_rvalid3  = 1'b1;
        m_rlast3   = 1'b1;
        m_rdata3   = 16'hBEEF;
        #1;
        check("rr3_rvalid", 64'(rvalid3), 64'd1 << g);
        check("rr3_rready", 64'(m_rready3), 64'd1);
        tick();
        m_rvalid3 = 1'b0;
        m_rlast3  = 1'b0;
        #1;
        check("rr3_busy_done", 64'(busy3), 64'd0);
    endtask

    int exp_rr [4] = '{0, 1, 0, 1};

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        req_araddr   = '0;
        req_arvalid  = '0;
        req_rready   = '0;
        m_arready    = 1'b0;
        m_rdata      = '0;
        m_rresp      = '0;
        m_rlast      = 1'b0;
        m_rvalid     = 1'b0;
        req_araddr3  = {16'h3C00, 16'h3B00, 16'h3A00};
        req_arvalid3 = '0;
        req_rready3  = 3'b111;
        m_arready3   = 1'b0;
        m_rdata3     = '0;
        m_rresp3     = '0;
        m_rlast3     = 1'b0;
        m_rvalid3    = 1'b0;

        // Reset values.
        #2;
        check("rst_busy", 64'(busy_rr), 64'd0);
        check("rst_arvalid", 64'(m_arvalid_rr), 64'd0);
        check("rst_araddr", m_araddr_rr, 64'd0);
        check("rst_grant", 64'(grant_rr), 64'd0);
        check("rst_arready", 64'(arready_rr), 64'd0);
        check("rst_busy3", 64'(busy3), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // R beats while idle are not accepted.
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        #1;
        check("idle_rready", 64'(m_rready_rr), 64'd0);
        check("idle_rvalid", 64'(rvalid_rr), 64'd0);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;

        // Single requester 1, with AR backpressure and an address change after grant.
        req_araddr[127:64] = 64'h1000;
        req_arvalid        = 2'b10;
        #1;
        check("ar_latency", 64'(m_arvalid_rr), 64'd0);
        tick();
        check("ar_valid", 64'(m_arvalid_rr), 64'd1);
        check("ar_addr", m_araddr_rr, 64'h1000);
        check("ar_grant", 64'(grant_rr), 64'd1);
        check("ar_busy", 64'(busy_rr), 64'd1);
        check("ar_no_ack", 64'(arready_rr), 64'd0);
        req_araddr[127:64] = 64'h2222;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_arvalid", 64'(m_arvalid_rr), 64'd1);
            check("bp_araddr", m_araddr_rr, 64'h1000);
        end
        m_arready = 1'b1;
        #1;
        check("ack_rr", 64'(arready_rr), 64'b10);
        check("ack_fp", 64'(arready_fp), 64'b10);
        tick();
        m_arready   = 1'b0;
        req_arvalid = 2'b00;
        #1;
        check("sr_arvalid_low", 64'(m_arvalid_rr), 64'd0);
        check("sr_busy", 64'(busy_rr), 64'd1);

        // Four-beat burst with a one-cycle R stall on beat 1.
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = 64'hD0 + 64'(b);
            m_rresp  = 2'(b);
            m_rlast  = (b == 3);
            if (b == 1) begin
                req_rready = 2'b00;
                #1;
                check("stall_rready", 64'(m_rready_rr), 64'd0);
                check("stall_rvalid", 64'(rvalid_rr), 64'b10);
                tick();
            end
            req_rready = 2'b10;
            #1;
            check("beat_rvalid", 64'(rvalid_rr), 64'b10);
            check("beat_rready", 64'(m_rready_rr), 64'd1);
            check("beat_rdata", rdata_rr, 64'hD0 + 64'(b));
            check("beat_rresp", 64'(rresp_rr), 64'(b));
            if (b == 3) check("beat_rlast", 64'(rlast_rr), 64'd1);
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        check("done_busy_rr", 64'(busy_rr), 64'd0);
        check("done_busy_fp", 64'(busy_fp), 64'd0);

        // Contention: both requesters held over four 2-beat bursts.
        req_araddr  = {64'hB000, 64'hA000};
        req_arvalid = 2'b11;
        req_rready  = 2'b11;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("cont_grant_rr", 64'(grant_rr), 64'(exp_rr[n]));
            check("cont_grant_fp", 64'(grant_fp), 64'd0);
            check("cont_addr_rr", m_araddr_rr, (exp_rr[n] == 1) ? 64'hB000 : 64'hA000);
            check("cont_addr_fp", m_araddr_fp, 64'hA000);
            m_arready = 1'b1;
            #1;
            check("cont_ack_rr", 64'(arready_rr), 64'd1 << exp_rr[n]);
            check("cont_ack_fp", 64'(arready_fp), 64'b01);
            tick();
            m_arready = 1'b0;
            for (int b = 0; b < 2; b++) begin
                m_rvalid = 1'b1;
                m_rlast  = (b == 1);
                #1;
                check("cont_rvalid_rr", 64'(rvalid_rr), 64'd1 << exp_rr[n]);
                check("cont_rvalid_fp", 64'(rvalid_fp), 64'b01);
                tick();
            end
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
        end
        req_arvalid = 2'b00;

        // Asynchronous reset in the middle of an R burst.
        req_araddr[63:0] = 64'h3000;
        req_arvalid      = 2'b01;
        tick();
        m_arready = 1'b1;
        tick();
        m_arready   = 1'b0;
        req_arvalid = 2'b00;
        m_rvalid    = 1'b1;
        #1;
        check("mid_rvalid", 64'(rvalid_rr), 64'b01);
        #2;
        reset = 1'b1;
        #1;
        check("async_rvalid", 64'(rvalid_rr), 64'd0);
        check("async_rready", 64'(m_rready_rr), 64'd0);
        check("async_busy", 64'(busy_rr), 64'd0);
        check("async_arvalid", 64'(m_arvalid_rr), 64'd0);
        check("async_araddr", m_araddr_rr, 64'd0);
        check("async_grant", 64'(grant_rr), 64'd0);
        check("async_busy_fp", 64'(busy_fp), 64'd0);
        m_rvalid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_busy", 64'(busy_rr), 64'd0);

        // Three-way round-robin with wrap of the pointer from 2 to 0.
        req_arvalid3 = 3'b110;
        burst3(1, 16'h3B00);
        req_arvalid3 = 3'b101;
        burst3(2, 16'h3C00);
        burst3(0, 16'h3A00);
        burst3(2, 16'h3C00);
        req_arvalid3 = 3'b000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
